rx_block_lock_ctrl: RTL and testbench
=====================================

Name: rx_block_lock_ctrl

Overview:
- Per-lane sync-header block-lock controller for the two receive lanes feeding the 64b/66b and 128b/132b decoder.
- Checks the sync header of each received block, hunts for alignment by requesting bit slips, and declares and maintains lock.
- Generates the decoder's enable_dec only when both lanes are locked.
- Sits between the lane deserialisers and the decoding datapath.

Parameters:
- LOCK_CNT, 64: consecutive valid headers required to declare lock.
- BAD_MAX, 16: invalid headers within one window that cause loss of lock.
- WIN, 64: monitoring window length in blocks while locked.
- SLIP_WAIT, 4: enc_clk cycles to wait after a slip before resuming hunt.

Ports:
- enc_clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- rx_en  in  1  receiver enable from link training; 0 forces IDLE
- gen_speed  in  2  00=GEN4, 01=GEN3, 10=GEN2, 11=reserved
- blk_valid  in  1  new block on both lanes this cycle
- lane_0_sync  in  4  lane 0 sync header (GEN2 uses [1:0])
- lane_1_sync  in  4  lane 1 sync header
- slip_0  out  1  one-cycle pulse: deserialiser shifts lane 0 by one bit
- slip_1  out  1  one-cycle pulse: same for lane 1
- block_lock  out  2  per-lane lock status, bit0 = lane 0
- enable_dec  out  1  decoder enable
- lock_lost  out  1  one-cycle pulse when any locked lane loses lock
- err_cnt  out  8  invalid headers seen while locked, saturating

Behaviour:
- Reset values: all outputs 0; all FSMs in IDLE; all counters 0.
- Header validity:
  - GEN2: hdr[1:0] is 01 or 10.
  - GEN3: hdr[3:0] is 0101 or 1010.
  - GEN4: no header; every block is valid.
  - Reserved speed: every header is invalid, so the lane never locks.
- Per-lane FSM states: IDLE, HUNT, SLIP, LOCKED.
- IDLE:
  - Holds good_cnt, bad_cnt, win_cnt at 0 and lock at 0.
  - rx_en=1 → HUNT, or → LOCKED directly when gen_speed=GEN4.
- HUNT: evaluated only on blk_valid.
  - Valid header: good_cnt+1. When good_cnt==LOCK_CNT-1 and the header is valid → LOCKED; lock=1 on that clock edge.
  - Invalid header: slip pulse on the next cycle, good_cnt=0, → SLIP.
- SLIP:
  - Counts SLIP_WAIT cycles; blk_valid is ignored; then → HUNT.
  - Exactly one slip pulse per invalid header.
- LOCKED: evaluated only on blk_valid.
  - win_cnt+1 per block; bad_cnt+1 per invalid header; err_cnt+1, saturating at 255.
  - bad_cnt reaching BAD_MAX → HUNT with lock=0, counters cleared, lock_lost pulsed next cycle; no slip is issued.
  - win_cnt reaching WIN-1 → win_cnt=0 and bad_cnt=0.
  - If both conditions occur on the same block, loss of lock wins.
- rx_en=0 in any state → IDLE on the next edge; err_cnt clears.
- A change of gen_speed while rx_en=1 (compared against a registered copy) → IDLE for that cycle, then re-hunt.
- enable_dec is registered: it equals rx_en & block_lock[0] & block_lock[1], one cycle after both locks are set. It deasserts one cycle after either lock drops or rx_en falls.
- The lanes are independent. Simultaneous events on both lanes give one lock_lost pulse, and err_cnt increments by 2 (saturating).
- Asynchronous reset mid-hunt or mid-slip aborts immediately; no slip pulse is emitted after reset.
- blk_valid high on consecutive cycles is legal; each high cycle is one block.

Decomposition:
- Shared package, usb4_rx_pkg:
  - gen_speed localparams GEN4/GEN3/GEN2.
  - Lock FSM state enum.
  - Valid-header constants 2'b01/2'b10 and 4'b0101/4'b1010.
  - Header-valid function taking (gen_speed, hdr).
- Sub-module lane_lock_fsm:
  - Contains the per-lane FSM, its counters and slip generation.
  - Instantiated twice.
  - Top level holds the speed-change detector, enable_dec, lock_lost merge and err_cnt.

Test Plan:
- GEN2, both lanes hdr 01 on 64 consecutive blk_valid:
  - block_lock=11 after the 64th block.
  - enable_dec=1 one cycle later.
  - No slips.
- GEN3, lane 1 hdr 0000 on block 10:
  - slip_1 single pulse.
  - Lane 1 idles 4 cycles, then relocks after 64 valid headers.
  - Lane 0 locks at block 64.
  - enable_dec waits for lane 1.
- GEN2 locked, 16 invalid headers within 64 blocks:
  - lock_lost pulse, block_lock=00.
  - enable_dec drops one cycle later.
  - err_cnt=32 (16 per lane).
- GEN2 locked, 15 invalid headers per window across 3 windows:
  - Lock held.
  - err_cnt saturates at 255 under an extended run.
- GEN4, rx_en rises:
  - block_lock=11 next edge, enable_dec the following edge.
  - Headers ignored.
- rx_en drop and gen_speed switch mid-hunt, plus reset asserted during SLIP:
  - All FSMs return to IDLE.
  - No slip pulse after reset.
  - err_cnt=0.

Source files
------------

// File: rtl/usb4_rx_pkg.sv
// rtl/usb4_rx_pkg.sv - shared speed codes, lock states and sync-header check
package usb4_rx_pkg;

    localparam logic [1:0] GEN4 = 2'b00;
    localparam logic [1:0] GEN3 = 2'b01;
    localparam logic [1:0] GEN2 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_SLIP   = 2'd2,
        ST_LOCKED = 2'd3
    } lock_state_t;

    localparam logic [1:0] HDR2_A = 2'b01;
    localparam logic [1:0] HDR2_B = 2'b10;
    localparam logic [3:0] HDR3_A = 4'b0101;
    localparam logic [3:0] HDR3_B = 4'b1010;

    // GEN4 carries no header so every block passes; the reserved code never passes
    function automatic logic hdr_valid(input logic [1:0] speed, input logic [3:0] hdr);
        logic ok;
        case (speed)
            GEN2:    ok = (hdr[1:0] == HDR2_A) || (hdr[1:0] == HDR2_B);
            GEN3:    ok = (hdr == HDR3_A) || (hdr == HDR3_B);
            GEN4:    ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lane_lock_fsm.sv
// rtl/lane_lock_fsm.sv - per-lane block-lock hunt/slip/lock state machine
module lane_lock_fsm
    import usb4_rx_pkg::*;
#(
    parameter int LOCK_CNT  = 64,
    parameter int BAD_MAX   = 16,
    parameter int WIN       = 64,
    parameter int SLIP_WAIT = 4
) (
    input  logic       enc_clk,
    input  logic       rst,
    input  logic       clr,
    input  logic [1:0] gen_speed,
    input  logic       blk_valid,
    input  logic [3:0] hdr,
    output logic       slip,
    output logic       lock,
    output logic       lost,
    output logic       err_inc
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(BAD_MAX + 1);
    localparam int WW = $clog2(WIN + 1);
    localparam int SW = $clog2(SLIP_WAIT + 1);

    lock_state_t   state, state_n;
    logic [GW-1:0] good_cnt, good_n;
    logic [BW-1:0] bad_cnt, bad_n;
    logic [WW-1:0] win_cnt, win_n;
    logic [SW-1:0] wait_cnt, wait_n;
    logic          lost_q, lost_n;
    logic          ok;

    assign ok = hdr_valid(gen_speed, hdr);

    // State and counter registers; reset drops straight to IDLE so no slip can follow
    always_ff @(posedge enc_clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            good_cnt <= '0;
            bad_cnt  <= '0;
            win_cnt  <= '0;
            wait_cnt <= '0;
            lost_q   <= 1'b0;
        end else begin
            state    <= state_n;
            good_cnt <= good_n;
            bad_cnt  <= bad_n;
            win_cnt  <= win_n;
            wait_cnt <= wait_n;
            lost_q   <= lost_n;
        end
    end

    // Next state and counter updates; clr (rx_en low or speed change) overrides everything
    always_comb begin
        state_n = state;
        good_n  = good_cnt;
        bad_n   = bad_cnt;
        win_n   = win_cnt;
        wait_n  = wait_cnt;
        lost_n  = 1'b0;
        if (clr) begin
            state_n = ST_IDLE;
            good_n  = '0;
            bad_n   = '0;
            win_n   = '0;
            wait_n  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    good_n  = '0;
                    bad_n   = '0;
                    win_n   = '0;
                    wait_n  = '0;
                    state_n = (gen_speed == GEN4) ? ST_LOCKED : ST_HUNT;
                end
                ST_HUNT: begin
                    if (blk_valid) begin
                        if (ok) begin
                            if (good_cnt == GW'(LOCK_CNT - 1)) begin
                                state_n = ST_LOCKED;
                                good_n  = '0;
                            end else begin
                                good_n = good_cnt + GW'(1);
                            end
                        end else begin
                            state_n = ST_SLIP;
                            good_n  = '0;
                            wait_n  = '0;
                        end
                    end
                end
                ST_SLIP: begin
                    if (wait_cnt == SW'(SLIP_WAIT - 1)) begin
                        state_n = ST_HUNT;
                        wait_n  = '0;
                    end else begin
                        wait_n = wait_cnt + SW'(1);
                    end
                end
                ST_LOCKED: begin
                    if (blk_valid) begin
                        // loss of lock takes priority over the window rollover
                        if (!ok && (bad_cnt == BW'(BAD_MAX - 1))) begin
                            state_n = ST_HUNT;
                            good_n  = '0;
                            bad_n   = '0;
                            win_n   = '0;
                            lost_n  = 1'b1;
                        end else if (win_cnt == WW'(WIN - 1)) begin
                            win_n = '0;
                            bad_n = '0;
                        end else begin
                            win_n = win_cnt + WW'(1);
                            if (!ok) begin
                                bad_n = bad_cnt + BW'(1);
                            end
                        end
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // Outputs: slip fires in the first SLIP cycle only, giving one pulse per bad header
    always_comb begin
        lock    = (state == ST_LOCKED);
        slip    = (state == ST_SLIP) && (wait_cnt == '0);
        lost    = lost_q;
        err_inc = (state == ST_LOCKED) && blk_valid && !ok && !clr;
    end

endmodule

// File: rtl/rx_block_lock_ctrl.sv
// rtl/rx_block_lock_ctrl.sv - two-lane sync-header block-lock controller and decoder enable
module rx_block_lock_ctrl
    import usb4_rx_pkg::*;
#(
    parameter int LOCK_CNT  = 64,
    parameter int BAD_MAX   = 16,
    parameter int WIN       = 64,
    parameter int SLIP_WAIT = 4
) (
    input  logic       enc_clk,
    input  logic       rst,
    input  logic       rx_en,
    input  logic [1:0] gen_speed,
    input  logic       blk_valid,
    input  logic [3:0] lane_0_sync,
    input  logic [3:0] lane_1_sync,
    output logic       slip_0,
    output logic       slip_1,
    output logic [1:0] block_lock,
    output logic       enable_dec,
    output logic       lock_lost,
    output logic [7:0] err_cnt
);

    logic [1:0] speed_q;
    logic       spd_chg;
    logic       clr;
    logic       lock_0, lock_1;
    logic       lost_0, lost_1;
    logic       inc_0, inc_1;
    logic [8:0] err_sum;

    assign spd_chg = rx_en && (gen_speed != speed_q);
    assign clr     = !rx_en || spd_chg;

    lane_lock_fsm #(
        .LOCK_CNT (LOCK_CNT),
        .BAD_MAX  (BAD_MAX),
        .WIN      (WIN),
        .SLIP_WAIT(SLIP_WAIT)
    ) u_lane_0 (
        .enc_clk  (enc_clk),
        .rst      (rst),
        .clr      (clr),
        .gen_speed(gen_speed),
        .blk_valid(blk_valid),
        .hdr      (lane_0_sync),
        .slip     (slip_0),
        .lock     (lock_0),
        .lost     (lost_0),
        .err_inc  (inc_0)
    );

    lane_lock_fsm #(
        .LOCK_CNT (LOCK_CNT),
        .BAD_MAX  (BAD_MAX),
        .WIN      (WIN),
        .SLIP_WAIT(SLIP_WAIT)
    ) u_lane_1 (
        .enc_clk  (enc_clk),
        .rst      (rst),
        .clr      (clr),
        .gen_speed(gen_speed),
        .blk_valid(blk_valid),
        .hdr      (lane_1_sync),
        .slip     (slip_1),
        .lock     (lock_1),
        .lost     (lost_1),
        .err_inc  (inc_1)
    );

    assign block_lock = {lock_1, lock_0};
    assign lock_lost  = lost_0 | lost_1;
    assign err_sum    = {1'b0, err_cnt} + {8'd0, inc_0} + {8'd0, inc_1};

    // Registered copy of gen_speed used to spot a speed change while enabled
    always_ff @(posedge enc_clk or negedge rst) begin
        if (!rst) begin
            speed_q <= GEN4;
        end else begin
            speed_q <= gen_speed;
        end
    end

    // Decoder enable follows both lane locks and rx_en by one cycle
    always_ff @(posedge enc_clk or negedge rst) begin
        if (!rst) begin
            enable_dec <= 1'b0;
        end else begin
            enable_dec <= rx_en & lock_0 & lock_1;
        end
    end

    // Saturating count of bad headers seen while locked; cleared whenever rx_en is low
    always_ff @(posedge enc_clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= 8'd0;
        end else if (!rx_en) begin
            err_cnt <= 8'd0;
        end else if (err_sum > 9'd255) begin
            err_cnt <= 8'd255;
        end else begin
            err_cnt <= err_sum[7:0];
        end
    end

endmodule

// File: tb/tb_rx_block_lock_ctrl.sv
// tb/tb_rx_block_lock_ctrl.sv - scenario bench for rx_block_lock_ctrl
module tb_rx_block_lock_ctrl;

    localparam logic [1:0] S_GEN4 = 2'b00;
    localparam logic [1:0] S_GEN3 = 2'b01;
    localparam logic [1:0] S_GEN2 = 2'b10;

    logic       enc_clk = 1'b0;
    logic       rst;
    logic       rx_en;
    logic [1:0] gen_speed;
    logic       blk_valid;
    logic [3:0] lane_0_sync;
    logic [3:0] lane_1_sync;
    logic       slip_0, slip_1;
    logic [1:0] block_lock;
    logic       enable_dec;
    logic       lock_lost;
    logic [7:0] err_cnt;

    int n_vec = 0;
    int n_bad = 0;
    int slip0_seen = 0;
    int slip1_seen = 0;
    int lost_seen = 0;

    typedef struct {
        logic [1:0] lock;
        logic       en;
        logic [7:0] err;
    } exp_t;
    exp_t sbq[$];

    always #5 enc_clk = ~enc_clk;

    rx_block_lock_ctrl dut (
        .enc_clk    (enc_clk),
        .rst        (rst),
        .rx_en      (rx_en),
        .gen_speed  (gen_speed),
        .blk_valid  (blk_valid),
        .lane_0_sync(lane_0_sync),
        .lane_1_sync(lane_1_sync),
        .slip_0     (slip_0),
        .slip_1     (slip_1),
        .block_lock (block_lock),
        .enable_dec (enable_dec),
        .lock_lost  (lock_lost),
        .err_cnt    (err_cnt)
    );

    task automatic step(input logic b, input logic [3:0] h0, input logic [3:0] h1);
        blk_valid   = b;
        lane_0_sync = h0;
        lane_1_sync = h1;
        @(posedge enc_clk);
        #1;
        slip0_seen += int'(slip_0);
        slip1_seen += int'(slip_1);
        lost_seen  += int'(lock_lost);
    endtask

    task automatic restart(input logic [1:0] spd);
        rx_en = 1'b0;
        step(1'b0, 4'h0, 4'h0);
        gen_speed = spd;
        step(1'b0, 4'h0, 4'h0);
        rx_en = 1'b1;
        step(1'b0, 4'h0, 4'h0);
        slip0_seen = 0;
        slip1_seen = 0;
        lost_seen  = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0; rx_en = 1'b0; gen_speed = S_GEN2;
        blk_valid = 1'b0; lane_0_sync = 4'h0; lane_1_sync = 4'h0;
        repeat (3) @(posedge enc_clk);
        #1;
        n_vec++; if (block_lock !== 2'b00) begin n_bad++; $display("FAIL reset_lock got %b want 00", block_lock); end
        n_vec++; if (enable_dec !== 1'b0) begin n_bad++; $display("FAIL reset_en got %b want 0", enable_dec); end
        n_vec++; if ({slip_1, slip_0} !== 2'b00) begin n_bad++; $display("FAIL reset_slip got %b want 00", {slip_1, slip_0}); end
        n_vec++; if (lock_lost !== 1'b0) begin n_bad++; $display("FAIL reset_lost got %b want 0", lock_lost); end
        n_vec++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_err got %0d want 0", err_cnt); end
        rst = 1'b1;
        step(1'b0, 4'h0, 4'h0);
    endtask

    task automatic test_gen2_lock();
        exp_t e;
        restart(S_GEN2);
        for (int i = 1; i <= 64; i++) begin
            sbq.push_back('{lock: (i == 64) ? 2'b11 : 2'b00, en: 1'b0, err: 8'd0});
            step(1'b1, 4'b0001, 4'b0001);
            e = sbq.pop_front();
            n_vec++; if (block_lock !== e.lock) begin n_bad++; $display("FAIL g2lock_lock blk %0d got %b want %b", i, block_lock, e.lock); end
            n_vec++; if (enable_dec !== e.en) begin n_bad++; $display("FAIL g2lock_en blk %0d got %b want %b", i, enable_dec, e.en); end
        end
        sbq.push_back('{lock: 2'b11, en: 1'b1, err: 8'd0});
        step(1'b0, 4'h0, 4'h0);
        e = sbq.pop_front();
        n_vec++; if (enable_dec !== e.en) begin n_bad++; $display("FAIL g2lock_en_late got %b want %b", enable_dec, e.en); end
        n_vec++; if (slip0_seen + slip1_seen != 0) begin n_bad++; $display("FAIL g2lock_slips got %0d want 0", slip0_seen + slip1_seen); end
    endtask

    task automatic test_gen3_slip();
        exp_t e;
        logic [3:0] h1;
        restart(S_GEN3);
        for (int b = 1; b <= 80; b++) begin
            h1 = (b == 10) ? 4'b0000 : 4'b0101;
            e.lock[0] = (b >= 64);
            e.lock[1] = (b >= 78);
            e.en = (b >= 79);
            e.err = 8'd0;
            sbq.push_back(e);
            step(1'b1, 4'b0101, h1);
            e = sbq.pop_front();
            n_vec++; if (block_lock !== e.lock) begin n_bad++; $display("FAIL g3slip_lock blk %0d got %b want %b", b, block_lock, e.lock); end
            n_vec++; if (enable_dec !== e.en) begin n_bad++; $display("FAIL g3slip_en blk %0d got %b want %b", b, enable_dec, e.en); end
            if (b == 10 || b == 11) begin
                n_vec++; if (slip_1 !== (b == 10)) begin n_bad++; $display("FAIL g3slip_pulse blk %0d got %b want %b", b, slip_1, (b == 10)); end
            end
        end
        n_vec++; if (slip1_seen != 1) begin n_bad++; $display("FAIL g3slip_count1 got %0d want 1", slip1_seen); end
        n_vec++; if (slip0_seen != 0) begin n_bad++; $display("FAIL g3slip_count0 got %0d want 0", slip0_seen); end
    endtask

    task automatic test_gen2_loss();
        exp_t e;
        restart(S_GEN2);
        for (int i = 1; i <= 63; i++) step(1'b1, 4'b0010, 4'b0010);
        sbq.push_back('{lock: 2'b11, en: 1'b0, err: 8'd0});
        step(1'b1, 4'b0010, 4'b0010);
        e = sbq.pop_front();
        n_vec++; if (block_lock !== e.lock) begin n_bad++; $display("FAIL loss_prelock got %b want %b", block_lock, e.lock); end
        step(1'b0, 4'h0, 4'h0);
        for (int k = 1; k <= 16; k++) begin
            sbq.push_back('{lock: (k == 16) ? 2'b00 : 2'b11, en: 1'b1, err: 8'(2 * k)});
            step(1'b1, 4'b0000, 4'b0011);
            e = sbq.pop_front();
            n_vec++; if (block_lock !== e.lock) begin n_bad++; $display("FAIL loss_lock bad %0d got %b want %b", k, block_lock, e.lock); end
            n_vec++; if (enable_dec !== e.en) begin n_bad++; $display("FAIL loss_en bad %0d got %b want %b", k, enable_dec, e.en); end
            n_vec++; if (err_cnt !== e.err) begin n_bad++; $display("FAIL loss_err bad %0d got %0d want %0d", k, err_cnt, e.err); end
            n_vec++; if (lock_lost !== (k == 16)) begin n_bad++; $display("FAIL loss_pulse bad %0d got %b want %b", k, lock_lost, (k == 16)); end
        end
        sbq.push_back('{lock: 2'b00, en: 1'b0, err: 8'd32});
        step(1'b0, 4'h0, 4'h0);
        e = sbq.pop_front();
        n_vec++; if (enable_dec !== e.en) begin n_bad++; $display("FAIL loss_en_drop got %b want %b", enable_dec, e.en); end
        n_vec++; if (err_cnt !== e.err) begin n_bad++; $display("FAIL loss_err_final got %0d want %0d", err_cnt, e.err); end
        n_vec++; if (lost_seen != 1) begin n_bad++; $display("FAIL loss_pulse_count got %0d want 1", lost_seen); end
        n_vec++; if (slip0_seen + slip1_seen != 0) begin n_bad++; $display("FAIL loss_slips got %0d want 0", slip0_seen + slip1_seen); end
    endtask

    task automatic test_gen2_hold();
        exp_t e;
        int errs;
        logic [3:0] h;
        restart(S_GEN2);
        for (int i = 1; i <= 64; i++) step(1'b1, 4'b0001, 4'b0010);
        for (int w = 1; w <= 9; w++) begin
            for (int p = 0; p < 64; p++) begin
                h = (p < 15) ? 4'b0011 : 4'b0001;
                errs = 30 * (w - 1) + 2 * ((p < 15) ? p + 1 : 15);
                if (errs > 255) errs = 255;
                sbq.push_back('{lock: 2'b11, en: 1'b1, err: 8'(errs)});
                step(1'b1, h, h);
                e = sbq.pop_front();
                n_vec++; if (block_lock !== e.lock) begin n_bad++; $display("FAIL hold_lock win %0d blk %0d got %b want %b", w, p, block_lock, e.lock); end
                n_vec++; if (enable_dec !== e.en) begin n_bad++; $display("FAIL hold_en win %0d blk %0d got %b want %b", w, p, enable_dec, e.en); end
                n_vec++; if (err_cnt !== e.err) begin n_bad++; $display("FAIL hold_err win %0d blk %0d got %0d want %0d", w, p, err_cnt, e.err); end
            end
        end
        n_vec++; if (lost_seen != 0) begin n_bad++; $display("FAIL hold_lost got %0d want 0", lost_seen); end
    endtask

    task automatic test_gen4();
        exp_t e;
        rx_en = 1'b0;
        sbq.push_back('{lock: 2'b00, en: 1'b0, err: 8'd0});
        step(1'b0, 4'h0, 4'h0);
        e = sbq.pop_front();
        n_vec++; if (err_cnt !== e.err) begin n_bad++; $display("FAIL g4_err_clear got %0d want %0d", err_cnt, e.err); end
        n_vec++; if (block_lock !== e.lock) begin n_bad++; $display("FAIL g4_idle_lock got %b want %b", block_lock, e.lock); end
        gen_speed = S_GEN4;
        step(1'b0, 4'h0, 4'h0);
        slip0_seen = 0; slip1_seen = 0;
        rx_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sbq.push_back('{lock: 2'b11, en: (i > 0), err: 8'd0});
            step(1'b1, 4'($urandom_range(15)), 4'($urandom_range(15)));
            e = sbq.pop_front();
            n_vec++; if (block_lock !== e.lock) begin n_bad++; $display("FAIL g4_lock cyc %0d got %b want %b", i, block_lock, e.lock); end
            n_vec++; if (enable_dec !== e.en) begin n_bad++; $display("FAIL g4_en cyc %0d got %b want %b", i, enable_dec, e.en); end
            n_vec++; if (err_cnt !== e.err) begin n_bad++; $display("FAIL g4_err cyc %0d got %0d want %0d", i, err_cnt, e.err); end
        end
        n_vec++; if (slip0_seen + slip1_seen != 0) begin n_bad++; $display("FAIL g4_slips got %0d want 0", slip0_seen + slip1_seen); end
    endtask

    task automatic test_abort();
        exp_t e;
        // rx_en drop mid-hunt must discard partial progress
        restart(S_GEN3);
        for (int i = 0; i < 40; i++) step(1'b1, 4'b0101, 4'b1010);
        rx_en = 1'b0;
        sbq.push_back('{lock: 2'b00, en: 1'b0, err: 8'd0});
        step(1'b1, 4'b0101, 4'b0101);
        e = sbq.pop_front();
        n_vec++; if (block_lock !== e.lock) begin n_bad++; $display("FAIL abort_rxen_lock got %b want %b", block_lock, e.lock); end
        rx_en = 1'b1;
        step(1'b0, 4'h0, 4'h0);
        for (int i = 1; i <= 64; i++) begin
            sbq.push_back('{lock: (i == 64) ? 2'b11 : 2'b00, en: 1'b0, err: 8'd0});
            step(1'b1, 4'b0101, 4'b0101);
            e = sbq.pop_front();
            if (i >= 20) begin
                n_vec++; if (block_lock !== e.lock) begin n_bad++; $display("FAIL abort_rehunt blk %0d got %b want %b", i, block_lock, e.lock); end
            end
        end
        // speed change mid-hunt: one IDLE cycle then a full re-hunt
        restart(S_GEN3);
        for (int i = 0; i < 50; i++) step(1'b1, 4'b0101, 4'b0101);
        gen_speed = S_GEN2;
        step(1'b1, 4'b0101, 4'b0101);
        step(1'b1, 4'b0101, 4'b0101);
        for (int i = 1; i <= 64; i++) begin
            sbq.push_back('{lock: (i == 64) ? 2'b11 : 2'b00, en: 1'b0, err: 8'd0});
            step(1'b1, 4'b0101, 4'b0101);
            e = sbq.pop_front();
            if (i >= 10) begin
                n_vec++; if (block_lock !== e.lock) begin n_bad++; $display("FAIL abort_spd blk %0d got %b want %b", i, block_lock, e.lock); end
            end
        end
        // asynchronous reset while lane 0 sits in SLIP
        restart(S_GEN2);
        step(1'b1, 4'b0000, 4'b0001);
        n_vec++; if (slip_0 !== 1'b1) begin n_bad++; $display("FAIL abort_slip_first got %b want 1", slip_0); end
        step(1'b0, 4'h0, 4'h0);
        n_vec++; if (slip_0 !== 1'b0) begin n_bad++; $display("FAIL abort_slip_width got %b want 0", slip_0); end
        #2 rst = 1'b0;
        #1;
        n_vec++; if (block_lock !== 2'b00) begin n_bad++; $display("FAIL abort_rst_lock got %b want 00", block_lock); end
        n_vec++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL abort_rst_err got %0d want 0", err_cnt); end
        repeat (3) step(1'b1, 4'b0000, 4'b0000);
        rst = 1'b1;
        repeat (6) step(1'b0, 4'h0, 4'h0);
        n_vec++; if (slip0_seen != 1) begin n_bad++; $display("FAIL abort_slip0_total got %0d want 1", slip0_seen); end
        n_vec++; if (slip1_seen != 0) begin n_bad++; $display("FAIL abort_slip1_total got %0d want 0", slip1_seen); end
        for (int i = 1; i <= 64; i++) begin
            sbq.push_back('{lock: (i == 64) ? 2'b11 : 2'b00, en: 1'b0, err: 8'd0});
            step(1'b1, 4'b0001, 4'b0010);
            e = sbq.pop_front();
            if (i >= 63) begin
                n_vec++; if (block_lock !== e.lock) begin n_bad++; $display("FAIL abort_relock blk %0d got %b want %b", i, block_lock, e.lock); end
                n_vec++; if (err_cnt !== e.err) begin n_bad++; $display("FAIL abort_relock_err blk %0d got %0d want %0d", i, err_cnt, e.err); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_gen2_lock();
        test_gen3_slip();
        test_gen2_loss();
        test_gen2_hold();
        test_gen4();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
